// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder: the add/subtract mode
// encoding and the helper that derives the per-stage chunk width.
package pipe_adder_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   // Bits handled by each pipeline stage; width must divide evenly by stages.
   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Valid/ready operand and result channels of the pipelined adder.
// The master side supplies operands and consumes results; the slave side
// is the adder itself.
interface pipe_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Out;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, A, B, sub, out_ready,
      input  in_ready, out_valid, Out, cout, ovf
   );

   modport slave (
      input  in_valid, A, B, sub, out_ready,
      output in_ready, out_valid, Out, cout, ovf
   );
endinterface

// File: rtl/pipe_adder_slice.sv
// Combinational chunk adder: one pipeline stage's slice of the carry chain.
module adder_slice #(
   parameter int CW = 16
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin,
   output logic [CW-1:0] sum,
   output logic          cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit. Operands are cut into STAGES chunks, LSB
// first; stage k adds chunk k with the carry registered by stage k-1 while
// the untouched upper chunks ride along. Each stage holds a valid bit and
// the pipeline collapses bubbles under valid/ready back-pressure.
// WIDTH must be at least 2 and divisible by STAGES.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input logic       clk,
   input logic       reset,
   input logic       flush,
   pipe_adder_if.slave bus
);

   localparam int CW = chunk_width(WIDTH, STAGES);

   logic [STAGES-1:0]            valid_vec;
   logic [STAGES-1:0]            free_vec;
   logic [STAGES-1:0]            carry_vec;
   logic [STAGES-1:0][WIDTH-1:0] sum_vec;
   logic [STAGES-1:0][WIDTH-1:0] a_vec;
   logic [STAGES-1:0][WIDTH-1:0] b_vec;
   logic                         take;
   logic                         unused_tail;

   // A stage can load when it is empty or its content moves on this edge;
   // the chain starts at the consumer's out_ready.
   always_comb begin : free_chain
      logic chain;
      chain    = bus.out_ready;
      free_vec = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         free_vec[k] = !valid_vec[k] || chain;
         chain       = free_vec[k];
      end
   end

   assign bus.in_ready = free_vec[0] && !flush && !reset;
   assign take         = bus.in_valid && bus.in_ready;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic [WIDTH-1:0] src_sum;
      logic             src_cin;
      logic [CW-1:0]    slice_sum;
      logic             slice_cout;
      logic [WIDTH-1:0] sum_next;
      logic             valid_reg;
      logic             carry_reg;
      logic [WIDTH-1:0] sum_reg;
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;

      if (gi == 0) begin : g_head
         // Subtraction is A + ~B + 1: invert B once here and feed sub as carry-in.
         assign src_cin   = (mode_e'(bus.sub) == MODE_SUB);
         assign src_valid = take;
         assign src_a     = bus.A;
         assign src_b     = src_cin ? ~bus.B : bus.B;
         assign src_sum   = '0;
      end else begin : g_body
         assign src_cin   = carry_vec[gi-1];
         assign src_valid = valid_vec[gi-1];
         assign src_a     = a_vec[gi-1];
         assign src_b     = b_vec[gi-1];
         assign src_sum   = sum_vec[gi-1];
      end

      adder_slice #(.CW(CW)) u_slice (
         .a    (src_a[gi*CW +: CW]),
         .b    (src_b[gi*CW +: CW]),
         .cin  (src_cin),
         .sum  (slice_sum),
         .cout (slice_cout)
      );

      // Merge this stage's chunk into the partial sum accumulated so far.
      always_comb begin
         sum_next                 = src_sum;
         sum_next[gi*CW +: CW]    = slice_sum;
      end

      // Stage register: reset clears everything, flush drops the valid bit,
      // otherwise load from the previous stage whenever this one is free.
      always_ff @(posedge clk) begin
         if (reset) begin
            valid_reg <= 1'b0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
         end else if (flush) begin
            valid_reg <= 1'b0;
         end else if (free_vec[gi]) begin
            valid_reg <= src_valid;
            if (src_valid) begin
               carry_reg <= slice_cout;
               sum_reg   <= sum_next;
               a_reg     <= src_a;
               b_reg     <= src_b;
            end
         end
      end

      assign valid_vec[gi] = valid_reg;
      assign carry_vec[gi] = carry_reg;
      assign sum_vec[gi]   = sum_reg;
      assign a_vec[gi]     = a_reg;
      assign b_vec[gi]     = b_reg;
   end

   // Results come straight from the last stage registers, so they stay put
   // while stalled. out_valid is masked in a cycle that discards the pipe.
   assign bus.out_valid = valid_vec[STAGES-1] && !flush && !reset;
   assign bus.Out       = sum_vec[STAGES-1];
   assign bus.cout      = carry_vec[STAGES-1];
   assign bus.ovf       = (a_vec[STAGES-1][WIDTH-1] == b_vec[STAGES-1][WIDTH-1]) &&
                          (sum_vec[STAGES-1][WIDTH-1] != a_vec[STAGES-1][WIDTH-1]);

   // Only the sign bits of the operands that reach the last stage matter.
   assign unused_tail = ^{a_vec[STAGES-1][WIDTH-2:0], b_vec[STAGES-1][WIDTH-2:0]};

endmodule
